// File: rtl/phys_reg_tracker.sv
// phys_reg_tracker: FREE/BUSY/CALCULATED tracking for one physical register file.
// Define PHYS_REG_TRACKER_BYPASS_EN to let same-cycle frees feed allocation.
module phys_reg_tracker #(
  parameter int NUM_REG = 32,
  parameter int ALLOC_W = 2,
  parameter int FREE_W  = 2,
  parameter int WB_W    = 2,
  localparam int AW = $clog2(NUM_REG),
  localparam int CW = $clog2(NUM_REG + 1)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [ALLOC_W-1:0]    alloc_req,
  output logic [ALLOC_W*AW-1:0] alloc_addr,
  output logic                  alloc_ready,
  input  logic [FREE_W-1:0]     free_valid,
  input  logic [FREE_W*AW-1:0]  free_addr,
  input  logic [WB_W-1:0]       wb_valid,
  input  logic [WB_W*AW-1:0]    wb_addr,
  input  logic                  restore,
  input  logic [NUM_REG-1:0]    restore_mask,
  output logic [NUM_REG-1:0]    calculated_list,
  output logic [CW-1:0]         free_count
);

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_BUSY = 2'd1,
    ST_CALC = 2'd2
  } reg_state_e;

  reg_state_e state_q [NUM_REG];
  reg_state_e state_d [NUM_REG];
  logic [CW-1:0] free_count_q;
  logic [CW-1:0] free_count_d;

  logic [NUM_REG-1:0] free_hit;
  logic [NUM_REG-1:0] wb_hit;
  logic [NUM_REG-1:0] cand;
  logic [NUM_REG-1:0] rem;
  logic [NUM_REG-1:0] grant;
  logic [CW-1:0]      n_avail;
  logic [CW-1:0]      n_req;
  logic               found;

  always_comb begin
    free_hit = '0;
    wb_hit   = '0;
    cand     = '0;
    for (int r = 0; r < NUM_REG; r++) begin
      for (int l = 0; l < FREE_W; l++)
        if (free_valid[l] && free_addr[l*AW +: AW] == AW'(r))
          free_hit[r] = 1'b1;
      for (int l = 0; l < WB_W; l++)
        if (wb_valid[l] && wb_addr[l*AW +: AW] == AW'(r))
          wb_hit[r] = 1'b1;
`ifdef PHYS_REG_TRACKER_BYPASS_EN
      cand[r] = (state_q[r] == ST_FREE) || free_hit[r];
`else
      cand[r] = (state_q[r] == ST_FREE);
`endif
    end
  end

  always_comb begin
    n_avail = '0;
    n_req   = '0;
    for (int r = 0; r < NUM_REG; r++)
      n_avail = n_avail + CW'(cand[r]);
    for (int i = 0; i < ALLOC_W; i++)
      n_req = n_req + CW'(alloc_req[i]);
    alloc_ready = (n_req <= n_avail) && !restore;
  end

  // Each requesting lane takes the lowest candidate left by earlier lanes.
  always_comb begin
    rem        = cand;
    grant      = '0;
    found      = 1'b0;
    alloc_addr = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      alloc_addr[i*AW +: AW] = AW'(i);
      found = 1'b0;
      if (alloc_req[i]) begin
        for (int r = 0; r < NUM_REG; r++) begin
          if (!found && rem[r]) begin
            found                  = 1'b1;
            rem[r]                 = 1'b0;
            grant[r]               = 1'b1;
            alloc_addr[i*AW +: AW] = AW'(r);
          end
        end
      end
    end
  end

  always_comb begin
    free_count_d = '0;
    for (int r = 0; r < NUM_REG; r++) begin
      state_d[r] = state_q[r];
      if (restore && restore_mask[r])
        state_d[r] = ST_FREE;
      else if (alloc_ready && grant[r])
        state_d[r] = ST_BUSY;
      else if (free_hit[r])
        state_d[r] = ST_FREE;
      else if (wb_hit[r] && state_q[r] == ST_BUSY)
        state_d[r] = ST_CALC;
      if (state_d[r] == ST_FREE)
        free_count_d = free_count_d + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int r = 0; r < NUM_REG; r++)
        state_q[r] <= ST_FREE;
      free_count_q <= CW'(NUM_REG);
    end else begin
      state_q      <= state_d;
      free_count_q <= free_count_d;
    end
  end

  always_comb begin
    calculated_list = '0;
    for (int r = 0; r < NUM_REG; r++)
      calculated_list[r] = (state_q[r] == ST_CALC);
  end

  assign free_count = free_count_q;

endmodule

// File: tb/tb_phys_reg_tracker.sv
// tb_phys_reg_tracker: directed and random checks of phys_reg_tracker
// against a list-based reference model.
module tb_phys_reg_tracker;

  localparam int NUM_REG = 32;
  localparam int ALLOC_W = 2;
  localparam int FREE_W  = 2;
  localparam int WB_W    = 2;
  localparam int AW      = 5;
  localparam int CW      = 6;
`ifdef PHYS_REG_TRACKER_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  n_rst;
  logic [ALLOC_W-1:0]    alloc_req;
  logic [ALLOC_W*AW-1:0] alloc_addr;
  logic                  alloc_ready;
  logic [FREE_W-1:0]     free_valid;
  logic [FREE_W*AW-1:0]  free_addr;
  logic [WB_W-1:0]       wb_valid;
  logic [WB_W*AW-1:0]    wb_addr;
  logic                  restore;
  logic [NUM_REG-1:0]    restore_mask;
  logic [NUM_REG-1:0]    calculated_list;
  logic [CW-1:0]         free_count;

  int n_tests = 0;
  int n_fail  = 0;

  // model: 0 = free, 1 = busy, 2 = calculated
  int mst [NUM_REG];
  int nxt [NUM_REG];
  bit exp_ready;
  int exp_addr [ALLOC_W];

  always #5 clk = ~clk;

  phys_reg_tracker #(
    .NUM_REG(NUM_REG), .ALLOC_W(ALLOC_W),
    .FREE_W(FREE_W), .WB_W(WB_W)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .alloc_req(alloc_req), .alloc_addr(alloc_addr),
    .alloc_ready(alloc_ready),
    .free_valid(free_valid), .free_addr(free_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .restore(restore), .restore_mask(restore_mask),
    .calculated_list(calculated_list),
    .free_count(free_count)
  );

  function automatic int m_free_cnt();
    int c = 0;
    for (int r = 0; r < NUM_REG; r++)
      if (mst[r] == 0) c++;
    return c;
  endfunction

  function automatic logic [NUM_REG-1:0] m_calc();
    logic [NUM_REG-1:0] v = '0;
    for (int r = 0; r < NUM_REG; r++)
      v[r] = (mst[r] == 2);
    return v;
  endfunction

  task automatic model_eval();
    int cands[$];
    bit freed [NUM_REG];
    int k;
    int nreq;
    for (int r = 0; r < NUM_REG; r++) freed[r] = 0;
    for (int l = 0; l < FREE_W; l++)
      if (free_valid[l]) freed[free_addr[l*AW +: AW]] = 1;
    for (int r = 0; r < NUM_REG; r++)
      if (mst[r] == 0 || (BYPASS && freed[r])) cands.push_back(r);
    nreq = $countones(alloc_req);
    exp_ready = (nreq <= cands.size()) && !restore;
    nxt = mst;
    for (int l = 0; l < WB_W; l++)
      if (wb_valid[l] && mst[wb_addr[l*AW +: AW]] == 1)
        nxt[wb_addr[l*AW +: AW]] = 2;
    for (int r = 0; r < NUM_REG; r++)
      if (freed[r]) nxt[r] = 0;
    k = 0;
    for (int i = 0; i < ALLOC_W; i++) begin
      exp_addr[i] = i;
      if (alloc_req[i] && exp_ready) begin
        exp_addr[i] = cands[k];
        nxt[cands[k]] = 1;
        k++;
      end
    end
    for (int r = 0; r < NUM_REG; r++)
      if (restore && restore_mask[r]) nxt[r] = 0;
    if (!n_rst)
      for (int r = 0; r < NUM_REG; r++) nxt[r] = 0;
  endtask

  task automatic clear_in();
    alloc_req = '0; free_valid = '0; free_addr = '0;
    wb_valid = '0; wb_addr = '0;
    restore = 1'b0; restore_mask = '0;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    mst = nxt;
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    n_rst = 1'b0;
    settle(); tick();
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_in();
    n_rst = 1'b0;
    settle(); tick();
    settle(); tick();
    n_rst = 1'b1;
    settle();
    n_tests++;
    if (free_count !== 6'd32) begin
      n_fail++; $display("FAIL reset_free_count got %0d want 32", free_count);
    end
    n_tests++;
    if (calculated_list !== '0) begin
      n_fail++; $display("FAIL reset_calc got %h want 0", calculated_list);
    end
    n_tests++;
    if (alloc_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got %b want 1", alloc_ready);
    end
    n_tests++;
    if (alloc_addr !== {5'd1, 5'd0}) begin
      n_fail++; $display("FAIL reset_addr got %h want %h", alloc_addr, {5'd1, 5'd0});
    end
  endtask

  task automatic test_alloc_wb();
    clear_in();
    alloc_req = 2'b11;
    settle();
    n_tests++;
    if (alloc_ready !== 1'b1 || alloc_addr !== {5'd1, 5'd0}) begin
      n_fail++;
      $display("FAIL alloc_pair got rdy=%b addr=%h want rdy=1 addr=%h",
               alloc_ready, alloc_addr, {5'd1, 5'd0});
    end
    tick();
    n_tests++;
    if (free_count !== 6'd30) begin
      n_fail++; $display("FAIL alloc_count got %0d want 30", free_count);
    end
    clear_in();
    wb_valid = 2'b11;
    wb_addr  = {5'd5, 5'd0};
    settle();
    n_tests++;
    if (calculated_list !== '0) begin
      n_fail++; $display("FAIL wb_same_cycle got %h want 0", calculated_list);
    end
    tick();
    n_tests++;
    if (calculated_list !== 32'h1 || free_count !== 6'd30) begin
      n_fail++;
      $display("FAIL wb_visible got calc=%h cnt=%0d want calc=1 cnt=30",
               calculated_list, free_count);
    end
  endtask

  task automatic test_full();
    int guard = 0;
    clear_in();
    while (m_free_cnt() > 1 && guard < 40) begin
      alloc_req = (m_free_cnt() >= 3) ? 2'b11 : 2'b01;
      settle(); tick();
      guard++;
    end
    clear_in();
    n_tests++;
    if (free_count !== 6'd1) begin
      n_fail++; $display("FAIL fill_count got %0d want 1", free_count);
    end
    alloc_req = 2'b11;
    settle();
    n_tests++;
    if (alloc_ready !== 1'b0) begin
      n_fail++; $display("FAIL short_ready got %b want 0", alloc_ready);
    end
    tick();
    n_tests++;
    if (free_count !== 6'd1) begin
      n_fail++; $display("FAIL short_nochange got %0d want 1", free_count);
    end
    alloc_req = 2'b10;
    settle();
    n_tests++;
    if (alloc_ready !== 1'b1 || alloc_addr[9:5] !== 5'd31) begin
      n_fail++;
      $display("FAIL last_reg got rdy=%b addr1=%0d want rdy=1 addr1=31",
               alloc_ready, alloc_addr[9:5]);
    end
    tick();
    n_tests++;
    if (free_count !== 6'd0) begin
      n_fail++; $display("FAIL empty_count got %0d want 0", free_count);
    end
  endtask

  task automatic test_bypass();
    clear_in();
    free_valid = 2'b01;
    free_addr  = {5'd0, 5'd7};
    alloc_req  = 2'b01;
    settle();
    n_tests++;
    if (BYPASS) begin
      if (alloc_ready !== 1'b1 || alloc_addr[4:0] !== 5'd7) begin
        n_fail++;
        $display("FAIL bypass_grant got rdy=%b addr=%0d want rdy=1 addr=7",
                 alloc_ready, alloc_addr[4:0]);
      end
      tick();
    end else begin
      if (alloc_ready !== 1'b0) begin
        n_fail++; $display("FAIL full_no_bypass got rdy=%b want 0", alloc_ready);
      end
      tick();
      n_tests++;
      if (free_count !== 6'd1) begin
        n_fail++; $display("FAIL freed_count got %0d want 1", free_count);
      end
      clear_in();
      alloc_req = 2'b01;
      settle();
      n_tests++;
      if (alloc_ready !== 1'b1 || alloc_addr[4:0] !== 5'd7) begin
        n_fail++;
        $display("FAIL realloc7 got rdy=%b addr=%0d want rdy=1 addr=7",
                 alloc_ready, alloc_addr[4:0]);
      end
      tick();
    end
    n_tests++;
    if (free_count !== 6'd0) begin
      n_fail++; $display("FAIL reg7_count got %0d want 0", free_count);
    end
    clear_in();
    wb_valid = 2'b01;
    wb_addr  = {5'd0, 5'd7};
    settle(); tick();
    n_tests++;
    if (calculated_list[7] !== 1'b1) begin
      n_fail++; $display("FAIL reg7_busy got calc7=%b want 1", calculated_list[7]);
    end
  endtask

  task automatic test_restore();
    do_reset();
    clear_in();
    alloc_req = 2'b11;
    settle(); tick();
    settle(); tick();
    clear_in();
    wb_valid = 2'b01;
    wb_addr  = {5'd0, 5'd2};
    settle(); tick();
    restore      = 1'b1;
    restore_mask = 32'h0000_000C;
    wb_valid     = 2'b01;
    wb_addr      = {5'd0, 5'd1};
    alloc_req    = 2'b11;
    settle();
    n_tests++;
    if (alloc_ready !== 1'b0) begin
      n_fail++; $display("FAIL restore_ready got %b want 0", alloc_ready);
    end
    tick();
    n_tests++;
    if (calculated_list !== 32'h2 || free_count !== 6'd30) begin
      n_fail++;
      $display("FAIL restore_state got calc=%h cnt=%0d want calc=2 cnt=30",
               calculated_list, free_count);
    end
    clear_in();
    alloc_req = 2'b11;
    settle();
    n_tests++;
    if (alloc_addr !== {5'd3, 5'd2}) begin
      n_fail++; $display("FAIL restore_realloc got %h want %h", alloc_addr, {5'd3, 5'd2});
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      alloc_req    = ALLOC_W'($urandom_range(0, 3));
      free_valid   = FREE_W'($urandom_range(0, 3));
      free_addr    = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      wb_valid     = WB_W'($urandom_range(0, 3));
      wb_addr      = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      restore      = ($urandom_range(0, 15) == 0);
      restore_mask = $urandom;
      settle();
      n_tests++;
      if (alloc_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL rnd_ready cyc=%0d got %b want %b", c, alloc_ready, exp_ready);
      end
      for (int i = 0; i < ALLOC_W; i++) begin
        if (exp_ready && alloc_req[i]) begin
          n_tests++;
          if (alloc_addr[i*AW +: AW] !== exp_addr[i][AW-1:0]) begin
            n_fail++;
            $display("FAIL rnd_addr cyc=%0d lane=%0d got %0d want %0d",
                     c, i, alloc_addr[i*AW +: AW], exp_addr[i]);
          end
        end
      end
      tick();
      n_tests++;
      if (calculated_list !== m_calc() || free_count !== CW'(m_free_cnt())) begin
        n_fail++;
        $display("FAIL rnd_state cyc=%0d got calc=%h cnt=%0d want calc=%h cnt=%0d",
                 c, calculated_list, free_count, m_calc(), m_free_cnt());
      end
    end
    clear_in();
  endtask

  task automatic test_reset_mid();
    do_reset();
    clear_in();
    alloc_req = 2'b11;
    for (int i = 0; i < 10; i++) begin
      settle(); tick();
    end
    clear_in();
    wb_valid = 2'b11;
    wb_addr  = {5'd1, 5'd0};
    settle(); tick();
    n_tests++;
    if (free_count !== 6'd12 || calculated_list !== 32'h3) begin
      n_fail++;
      $display("FAIL pre_rst got cnt=%0d calc=%h want cnt=12 calc=3",
               free_count, calculated_list);
    end
    clear_in();
    alloc_req = 2'b11;
    n_rst = 1'b0;
    settle(); tick();
    n_tests++;
    if (free_count !== 6'd32 || calculated_list !== '0) begin
      n_fail++;
      $display("FAIL mid_rst got cnt=%0d calc=%h want cnt=32 calc=0",
               free_count, calculated_list);
    end
    n_rst = 1'b1;
    settle();
    n_tests++;
    if (alloc_ready !== 1'b1 || alloc_addr !== {5'd1, 5'd0}) begin
      n_fail++;
      $display("FAIL post_rst_alloc got rdy=%b addr=%h want rdy=1 addr=%h",
               alloc_ready, alloc_addr, {5'd1, 5'd0});
    end
    tick();
    clear_in();
  endtask

  initial begin
    for (int r = 0; r < NUM_REG; r++) mst[r] = 0;
    n_rst = 1'b0;
    clear_in();
    test_reset();
    test_alloc_wb();
    test_full();
    test_bypass();
    test_restore();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
